// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: word/address widths,
// register-address type and the hardwired-zero register index.
package mips_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Pending-write count per register; saturates at PC_MAX.
  typedef logic [1:0] pcnt_t;
  localparam pcnt_t PC_MAX  = 2'd3;
  localparam pcnt_t PC_NONE = 2'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/issue/read bundle between decode, MEM/WB and the register file.
// master = pipeline side driving requests, slave = register file.
interface wb_regfile_if;
  import mips_pkg::*;

  word_t     ans_wb;
  reg_addr_t wb_addr;
  logic      wb_en;
  logic      iss_en;
  reg_addr_t iss_addr;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  word_t     rs_data;
  word_t     rt_data;
  logic      stall;
  logic      sb_err;

  modport master (
    output ans_wb, wb_addr, wb_en, iss_en, iss_addr, rs_addr, rt_addr,
    input  rs_data, rt_data, stall, sb_err
  );

  modport slave (
    input  ans_wb, wb_addr, wb_en, iss_en, iss_addr, rs_addr, rt_addr,
    output rs_data, rt_data, stall, sb_err
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, sticky overflow/underflow flag and
// decode stall. Optional macro WB_BYPASS_EN discounts a same-cycle writeback.
module wb_scoreboard
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      stall,
  output logic      sb_err
);

  pcnt_t [NREG-1:0] pc;
  pcnt_t [NREG-1:0] pc_nxt;
  logic  [NREG-1:0] inc;
  logic  [NREG-1:0] dec;
  logic  [NREG-1:0] ovf;
  logic  [NREG-1:0] unf;
  logic             busy_rs;
  logic             busy_rt;

  // An issue and a writeback to the same register cancel; r0 never counts.
  always_comb begin
    pc_nxt = pc;
    inc    = '0;
    dec    = '0;
    ovf    = '0;
    unf    = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_en && (iss_addr == reg_addr_t'(r));
      dec[r] = wb_en  && (wb_addr  == reg_addr_t'(r));
      if (inc[r] && !dec[r]) begin
        if (pc[r] == PC_MAX) ovf[r] = 1'b1;
        else                 pc_nxt[r] = pc[r] + 2'd1;
      end else if (dec[r] && !inc[r]) begin
        if (pc[r] == PC_NONE) unf[r] = 1'b1;
        else                  pc_nxt[r] = pc[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      sb_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (|ovf || |unf) sb_err <= 1'b1;
    end
  end

  // With forwarding, a matching writeback retires one pending write now.
  always_comb begin
    busy_rs = (rs_addr != REG_ZERO) && (pc[rs_addr] != PC_NONE);
    busy_rt = (rt_addr != REG_ZERO) && (pc[rt_addr] != PC_NONE);
`ifdef WB_BYPASS_EN
    if (wb_en && (wb_addr == rs_addr) && (rs_addr != REG_ZERO))
      busy_rs = (pc[rs_addr] > 2'd1);
    if (wb_en && (wb_addr == rt_addr) && (rt_addr != REG_ZERO))
      busy_rt = (pc[rt_addr] > 2'd1);
`endif
    stall = busy_rs || busy_rt;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-side 8x16 register file with two combinational read ports and
// pending-write scoreboard. Optional macro WB_BYPASS_EN enables forwarding.
module wb_regfile
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  word_t [NREG-1:0] regs;
  word_t            rs_val;
  word_t            rt_val;
  logic             sb_stall;
  logic             sb_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (bus.wb_en && (bus.wb_addr != REG_ZERO)) begin
      regs[bus.wb_addr] <= bus.ans_wb;
    end
  end

  always_comb begin
    rs_val = (bus.rs_addr == REG_ZERO) ? '0 : regs[bus.rs_addr];
    rt_val = (bus.rt_addr == REG_ZERO) ? '0 : regs[bus.rt_addr];
`ifdef WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == bus.rs_addr) && (bus.rs_addr != REG_ZERO))
      rs_val = bus.ans_wb;
    if (bus.wb_en && (bus.wb_addr == bus.rt_addr) && (bus.rt_addr != REG_ZERO))
      rt_val = bus.ans_wb;
`endif
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .rs_addr  (bus.rs_addr),
    .rt_addr  (bus.rt_addr),
    .stall    (sb_stall),
    .sb_err   (sb_err_q)
  );

  assign bus.rs_data = rs_val;
  assign bus.rt_data = rt_val;
  assign bus.stall   = sb_stall;
  assign bus.sb_err  = sb_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an arithmetic reference model of registers and counts.
module tb_wb_regfile;
  import mips_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_regs [NREG];
  int          m_pc   [NREG];
  bit          m_err;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 0;
      m_pc[i]   = 0;
    end
    m_err = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    int d;
    int n;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.ans_wb;
      for (int r = 1; r < NREG; r++) begin
        d = 0;
        if (bus.iss_en && int'(bus.iss_addr) == r) d = d + 1;
        if (bus.wb_en  && int'(bus.wb_addr)  == r) d = d - 1;
        n = m_pc[r] + d;
        if (n > 3) begin n = 3; m_err = 1'b1; end
        if (n < 0) begin n = 0; m_err = 1'b1; end
        m_pc[r] = n;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.ans_wb   = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  function automatic logic [15:0] exp_rd(input int a);
    if (a == 0) return 16'h0000;
    if (BYPASS && bus.wb_en && int'(bus.wb_addr) == a) return bus.ans_wb;
    return 16'(m_regs[a]);
  endfunction

  function automatic logic exp_busy(input int a);
    int c;
    if (a == 0) return 1'b0;
    c = m_pc[a];
    if (BYPASS && bus.wb_en && int'(bus.wb_addr) == a) c = c - 1;
    return c > 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.rs_addr = 3'd1;
    bus.rt_addr = 3'd5;
    model_clear();
    #1;
    n_cmp++; if (bus.rs_data !== 16'h0) begin n_bad++; $display("FAIL reset_hold_rs: got %h want 0000", bus.rs_data); end
    n_cmp++; if (bus.rt_data !== 16'h0) begin n_bad++; $display("FAIL reset_hold_rt: got %h want 0000", bus.rt_data); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_hold_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL reset_hold_err: got %b want 0", bus.sb_err); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h0) begin n_bad++; $display("FAIL reset_release_rd: got %h/%h want 0000/0000", bus.rs_data, bus.rt_data); end
    n_cmp++; if (bus.stall !== 1'b0 || bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL reset_release_flags: got stall=%b err=%b want 0/0", bus.stall, bus.sb_err); end
  endtask

  task automatic test_write_read();
    bus.iss_en = 1'b1; bus.iss_addr = 3'd3;
    tick();
    bus.iss_en = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.ans_wb = 16'h1234;
    bus.rs_addr = 3'd3;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.rs_data !== 16'h1234) begin n_bad++; $display("FAIL write_r3: got %h want 1234", bus.rs_data); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL write_r3_stall: got %b want 0", bus.stall); end
  endtask

  task automatic test_r0();
    bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.ans_wb = 16'hFFFF;
    bus.rs_addr = 3'd0; bus.rt_addr = 3'd0;
    #1;
    n_cmp++; if (bus.rs_data !== 16'h0) begin n_bad++; $display("FAIL r0_same_cycle: got %h want 0000", bus.rs_data); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h0) begin n_bad++; $display("FAIL r0_after: got %h/%h want 0000/0000", bus.rs_data, bus.rt_data); end
    n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL r0_no_count: got err=%b want 0", bus.sb_err); end
  endtask

  task automatic test_same_cycle();
    bus.iss_en = 1'b1; bus.iss_addr = 3'd4;
    bus.rs_addr = 3'd0; bus.rt_addr = 3'd4;
    tick();
    bus.iss_en = 1'b0;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL r4_pending_stall: got %b want 1", bus.stall); end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.ans_wb = 16'hBEEF;
    #1;
    n_cmp++; if (bus.rt_data !== (BYPASS ? 16'hBEEF : 16'h0000)) begin n_bad++; $display("FAIL r4_fwd: got %h want %h", bus.rt_data, BYPASS ? 16'hBEEF : 16'h0000); end
    n_cmp++; if (bus.stall !== !BYPASS) begin n_bad++; $display("FAIL r4_fwd_stall: got %b want %b", bus.stall, !BYPASS); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.rt_data !== 16'hBEEF) begin n_bad++; $display("FAIL r4_after: got %h want beef", bus.rt_data); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL r4_after_stall: got %b want 0", bus.stall); end
  endtask

  task automatic test_stall();
    bus.rs_addr = 3'd2; bus.rt_addr = 3'd0;
    bus.iss_en = 1'b1; bus.iss_addr = 3'd2;
    tick();
    tick();
    idle();
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL r2_two_pending: got %b want 1", bus.stall); end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.ans_wb = 16'h2222;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL r2_first_wb: got %b want 1", bus.stall); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL r2_one_pending: got %b want 1", bus.stall); end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.ans_wb = 16'h2223;
    #1;
    n_cmp++; if (bus.stall !== !BYPASS) begin n_bad++; $display("FAIL r2_last_wb_stall: got %b want %b", bus.stall, !BYPASS); end
    n_cmp++; if (bus.rs_data !== (BYPASS ? 16'h2223 : 16'h2222)) begin n_bad++; $display("FAIL r2_last_wb_data: got %h want %h", bus.rs_data, BYPASS ? 16'h2223 : 16'h2222); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.stall !== 1'b0 || bus.rs_data !== 16'h2223) begin n_bad++; $display("FAIL r2_done: got stall=%b data=%h want 0/2223", bus.stall, bus.rs_data); end
  endtask

  task automatic test_overflow();
    bus.rs_addr = 3'd6; bus.rt_addr = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      bus.iss_en = 1'b1; bus.iss_addr = 3'd6;
      tick();
      idle();
      #1;
      n_cmp++; if (bus.sb_err !== (k == 4)) begin n_bad++; $display("FAIL r6_issue%0d_err: got %b want %b", k, bus.sb_err, (k == 4)); end
    end
    bus.iss_en = 1'b1; bus.iss_addr = 3'd6;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd6; bus.ans_wb = 16'h6666;
    tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      bus.wb_en = 1'b1; bus.wb_addr = 3'd6; bus.ans_wb = 16'(16'h6000 + k);
      tick();
      idle();
      #1;
      n_cmp++; if (bus.stall !== (k < 3)) begin n_bad++; $display("FAIL r6_drain%0d_stall: got %b want %b", k, bus.stall, (k < 3)); end
    end
    n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL r6_err_sticky: got %b want 1", bus.sb_err); end
  endtask

  task automatic test_underflow_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL uf_pre_err: got %b want 0", bus.sb_err); end
    bus.rs_addr = 3'd7; bus.rt_addr = 3'd3;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd7; bus.ans_wb = 16'h7777;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL uf_err: got %b want 1", bus.sb_err); end
    n_cmp++; if (bus.rs_data !== 16'h7777) begin n_bad++; $display("FAIL uf_data: got %h want 7777", bus.rs_data); end
    reset = 1'b1;
    #1;
    model_clear();
    n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL async_rst_err: got %b want 0", bus.sb_err); end
    n_cmp++; if (bus.rs_data !== 16'h0 || bus.rt_data !== 16'h0) begin n_bad++; $display("FAIL async_rst_regs: got %h/%h want 0000/0000", bus.rs_data, bus.rt_data); end
    #1;
    reset = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 3'd7; bus.ans_wb = 16'h7001;
    tick();
    idle();
    #1;
    n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL post_rst_uf: got %b want 1", bus.sb_err); end
  endtask

  task automatic test_random();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 300; i++) begin
      bus.iss_en   = ($urandom_range(0, 2) == 0);
      bus.iss_addr = 3'($urandom_range(0, 7));
      bus.wb_en    = ($urandom_range(0, 2) == 0);
      bus.wb_addr  = 3'($urandom_range(0, 7));
      bus.ans_wb   = 16'($urandom);
      bus.rs_addr  = 3'($urandom_range(0, 7));
      bus.rt_addr  = 3'($urandom_range(0, 7));
      #1;
      n_cmp++; if (bus.rs_data !== exp_rd(int'(bus.rs_addr))) begin n_bad++; $display("FAIL rnd%0d_rs: got %h want %h", i, bus.rs_data, exp_rd(int'(bus.rs_addr))); end
      n_cmp++; if (bus.rt_data !== exp_rd(int'(bus.rt_addr))) begin n_bad++; $display("FAIL rnd%0d_rt: got %h want %h", i, bus.rt_data, exp_rd(int'(bus.rt_addr))); end
      n_cmp++; if (bus.stall !== (exp_busy(int'(bus.rs_addr)) || exp_busy(int'(bus.rt_addr)))) begin n_bad++; $display("FAIL rnd%0d_stall: got %b want %b", i, bus.stall, exp_busy(int'(bus.rs_addr)) || exp_busy(int'(bus.rt_addr))); end
      n_cmp++; if (bus.sb_err !== m_err) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, bus.sb_err, m_err); end
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_same_cycle();
    test_stall();
    test_overflow();
    test_underflow_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file for the 16-bit MIPS pipeline: the consumer at the far end of the MEM/WB pipeline register. It takes the registered writeback word `ans_wb` with its destination address and write enable, stores it in an 8×16 register file, and serves two combinational read ports to decode. A per-register pending-write scoreboard raises a decode stall while an operand still has writes in flight between issue and writeback.

## Interface
- `DATA_W`, 16, data word width
- `NREG`, 8, number of architectural registers (r0 hardwired zero)
- `ADDR_W`, 3, register address width, equal to log2(`NREG`)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `ans_wb`  in  DATA_W  writeback data from MEM/WB register
- `wb_addr`  in  ADDR_W  writeback destination register
- `wb_en`  in  1  writeback strobe, one write per cycle
- `iss_en`  in  1  decode issued an instruction that will write `iss_addr`
- `iss_addr`  in  ADDR_W  destination of issued instruction
- `rs_addr`, `rt_addr`  in  ADDR_W  read addresses
- `rs_data`, `rt_data`  out  DATA_W  combinational read data
- `stall`  out  1  an operand has an outstanding write
- `sb_err`  out  1  sticky scoreboard overflow/underflow flag

## Operation
- Register write: on rising `clk` with `wb_en`=1 and `wb_addr`≠0, `regs[wb_addr]` ← `ans_wb`. Writes to r0 are discarded.
- Reads: `rs_data` = `regs[rs_addr]`, `rt_data` = `regs[rt_addr]`. Address 0 always returns 0.
- Scoreboard: each register r1..r7 has a 2-bit pending count `pc[r]`. Register r0 never counts.
  - An issue (`iss_en`, `iss_addr`≠0) increments the count.
  - A writeback (`wb_en`, `wb_addr`≠0) decrements the count.
  - An issue and a writeback to the same register in the same cycle leave the count unchanged.
  - Issue at count 3: the count holds at 3 and `sb_err` is set.
  - Writeback at count 0: the count holds at 0 and `sb_err` is set. The data write still occurs.
- `stall` = (`pc[rs_addr]`≠0) OR (`pc[rt_addr]`≠0), with address 0 contributing 0. This is modified by the bypass rule under Configuration.
- `sb_err` is sticky and clears only on `reset`.

## Timing
- Reset (asynchronous, immediate):
  - all `regs` = 0, all `pc` = 0, `sb_err` = 0
  - hence `rs_data` = `rt_data` = 0 and `stall` = 0
- Write latency: data written at edge N is readable from edge N onward (zero-cycle read-after-edge).
- Scoreboard counts update at the clock edge. `stall` is combinational from the counts and the read addresses.
- Reset asserted mid-operation discards all pending counts. Writebacks that arrive after reset release are counted as underflow and set `sb_err`.

## Configuration
- `WB_BYPASS_EN` defined:
  - Same-cycle write-to-read forwarding. When `wb_en`=1 and `wb_addr`=`rs_addr`≠0, `rs_data` = `ans_wb` in that cycle; the same rule applies to `rt`.
  - The stall term for that operand is computed as if its count were already decremented. A count of 1 with a matching writeback does not stall.
- `WB_BYPASS_EN` undefined:
  - Reads return the stored value only.
  - Stall uses the raw counts, so decode waits one extra cycle after the final writeback.

## Structure
- Shared package `mips_pkg`: `DATA_W`, `ADDR_W`, `NREG`, the register-address typedef, and the `REG_ZERO` constant.
- One sub-module, `wb_scoreboard`: the pending counters, error flag and stall logic. The top level holds the storage array and read/bypass muxing.

## Test plan
- Reset hold, then release with reads of r1/r5 → `rs_data`=`rt_data`=0, `stall`=0, `sb_err`=0.
- Write r3←0x1234 at edge N, read `rs_addr`=3 after N → 0x1234. Write r0←0xFFFF, read r0 → 0x0000.
- Same cycle: `wb_en`, `wb_addr`=4, `ans_wb`=0xBEEF, `rt_addr`=4:
  - with `WB_BYPASS_EN` → `rt_data`=0xBEEF combinationally
  - without → `rt_data`=0xBEEF only after the edge
- Issue r2 twice, read `rs_addr`=2 → `stall`=1. After one writeback → still 1. After the second writeback → 0, one cycle earlier with bypass.
- Issue r6 four times → `pc`=3 and `sb_err`=1. Simultaneous issue+writeback to r6 → count unchanged.
- Writeback to r7 at count 0 → `sb_err`=1 and data written. Assert `reset` asynchronously between edges → `sb_err` and all registers 0 immediately.
